// File: rtl/mm_pkg.sv
// Shared dimensions and the readout state encoding for the matrix-multiply result path.
package mm_pkg;
   localparam int DIM    = 16;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int IDX_W  = ADDR_W / 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN
   } rd_state_t;

   // Width of one buffered word: data plus row, column and last tag.
   function automatic int tag_word_w(input int data_w, input int idx_w);
      return data_w + 2 * idx_w + 1;
   endfunction
endpackage

// File: rtl/c_skid_fifo.sv
// Small shift-style FIFO: entry 0 is always the head, so the output is a plain register.
module c_skid_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem_reg  [DEPTH];
   logic [WIDTH-1:0] mem_next [DEPTH];
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] wr_idx;
   logic             do_pop;
   logic             do_push;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CNT_W'(DEPTH));
   assign count    = count_reg;
   assign pop_data = mem_reg[0];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   // A simultaneous pop shifts everything down, so the write slot moves down too.
   assign wr_idx   = do_pop ? (count_reg - CNT_W'(1)) : count_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] above;
         if (gi < DEPTH - 1) begin : g_mid
            assign above = mem_reg[gi+1];
         end else begin : g_top
            assign above = mem_reg[gi];
         end
         assign mem_next[gi] = (do_push && (wr_idx == CNT_W'(gi))) ? push_data :
                               (do_pop ? above : mem_reg[gi]);
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= mem_next[i];
         end
      end
   end
endmodule

// File: rtl/c_readout.sv
// Drains result matrix C from bram_c port B and streams it out with row/col/last tags.
module c_readout #(
   parameter int DIM    = mm_pkg::DIM,
   parameter int ADDR_W = mm_pkg::ADDR_W,
   parameter int DATA_W = mm_pkg::DATA_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                col_major,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   c_address,
   output logic                c_wren,
   output logic [DATA_W-1:0]   c_data,
   input  logic [DATA_W-1:0]   c_q,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [ADDR_W/2-1:0] out_row,
   output logic [ADDR_W/2-1:0] out_col,
   output logic                out_last
);
   import mm_pkg::*;

   localparam int IXW = ADDR_W / 2;
   localparam int FW  = tag_word_w(DATA_W, IXW);
   localparam logic [IXW-1:0] LAST_IDX = IXW'(DIM - 1);

   rd_state_t      state_reg;
   logic           col_major_reg;
   logic [IXW-1:0] outer_reg;
   logic [IXW-1:0] inner_reg;
   logic           inflight_reg;
   logic [IXW-1:0] infl_row_reg;
   logic [IXW-1:0] infl_col_reg;
   logic           infl_last_reg;
   logic           busy_reg;
   logic           done_reg;
   logic [ADDR_W-1:0] addr_reg;

   logic [IXW-1:0] cur_row, cur_col, nxt_row, nxt_col;
   logic [IXW-1:0] outer_next, inner_next;
   logic           cur_last;
   logic [ADDR_W-1:0] next_addr;
   logic [2:0]     pending;
   logic           issue;
   logic           drained;

   logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [1:0]     fifo_count;
   logic [FW-1:0]  fifo_din, fifo_dout;

   // c_address always holds the word the counters point at; the BRAM samples it every
   // edge, and an edge on which issue is high is the one that counts as a read.
   always_comb begin
      cur_row    = col_major_reg ? inner_reg : outer_reg;
      cur_col    = col_major_reg ? outer_reg : inner_reg;
      cur_last   = (outer_reg == LAST_IDX) && (inner_reg == LAST_IDX);
      inner_next = (inner_reg == LAST_IDX) ? '0 : inner_reg + IXW'(1);
      outer_next = (inner_reg == LAST_IDX) ? outer_reg + IXW'(1) : outer_reg;
      nxt_row    = col_major_reg ? inner_next : outer_next;
      nxt_col    = col_major_reg ? outer_next : inner_next;
      next_addr  = ADDR_W'(nxt_row) * ADDR_W'(DIM) + ADDR_W'(nxt_col);
   end

   assign fifo_pop  = !fifo_empty && out_ready;
   assign fifo_push = inflight_reg;
   // Words owed to the FIFO after this edge; counting the current pop avoids a bubble.
   assign pending   = 3'(fifo_count) + 3'(inflight_reg) - 3'(fifo_pop);
   assign issue     = (state_reg == ST_READ) && (pending < 3'd2) && !(fifo_full && !fifo_pop);
   assign drained   = !inflight_reg && (pending == 3'd0);
   assign fifo_din  = {infl_last_reg, infl_row_reg, infl_col_reg, c_q};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         col_major_reg <= 1'b0;
         outer_reg     <= '0;
         inner_reg     <= '0;
         inflight_reg  <= 1'b0;
         infl_row_reg  <= '0;
         infl_col_reg  <= '0;
         infl_last_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         addr_reg      <= '0;
      end else begin
         done_reg     <= 1'b0;
         inflight_reg <= issue;
         if (issue) begin
            infl_row_reg  <= cur_row;
            infl_col_reg  <= cur_col;
            infl_last_reg <= cur_last;
         end
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  col_major_reg <= col_major;
                  outer_reg     <= '0;
                  inner_reg     <= '0;
                  addr_reg      <= '0;
                  busy_reg      <= 1'b1;
                  state_reg     <= ST_READ;
               end
            end
            ST_READ: begin
               if (issue) begin
                  if (cur_last) begin
                     state_reg <= ST_DRAIN;
                  end else begin
                     outer_reg <= outer_next;
                     inner_reg <= inner_next;
                     addr_reg  <= next_addr;
                  end
               end
            end
            ST_DRAIN: begin
               if (drained) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   c_skid_fifo #(
      .WIDTH (FW),
      .DEPTH (2)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_din),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign c_address = addr_reg;
   assign c_wren    = 1'b0;
   assign c_data    = '0;
   assign out_valid = !fifo_empty;
   assign {out_last, out_row, out_col, out_data} = fifo_dout;
endmodule

// File: tb/tb_c_readout.sv
// Bench for c_readout: BRAM model, queue-based order model and a per-cycle stream checker.
module tb_c_readout;
   localparam int N     = 16;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int IW    = 4;
   localparam int WORDS = N * N;

   logic          clock = 1'b0;
   logic          reset, start, col_major, out_ready;
   logic          busy, done, c_wren, out_valid, out_last;
   logic [AW-1:0] c_address;
   logic [DW-1:0] c_data, c_q, out_data;
   logic [IW-1:0] out_row, out_col;

   always #5 clock = ~clock;

   c_readout dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .col_major (col_major),
      .busy      (busy),
      .done      (done),
      .c_address (c_address),
      .c_wren    (c_wren),
      .c_data    (c_data),
      .c_q       (c_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last)
   );

   // bram_c port B: registered read
   logic [DW-1:0] mem [WORDS];
   always @(posedge clock) c_q <= mem[c_address];

   typedef struct {
      logic [DW-1:0] data;
      logic [IW-1:0] row;
      logic [IW-1:0] col;
      logic          last;
   } exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int n_xfer = 0;
   int done_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Expected stream order straight from the matrix definition C[i][j] = i*256 + j.
   task automatic load_exp(input logic cm);
      exp_t e;
      int r, c;
      exp_q.delete();
      for (int k = 0; k < WORDS; k++) begin
         r = cm ? (k % N) : (k / N);
         c = cm ? (k / N) : (k % N);
         e.row  = IW'(r);
         e.col  = IW'(c);
         e.data = DW'(r * 256 + c);
         e.last = (k == WORDS - 1);
         exp_q.push_back(e);
      end
   endtask

   // Stream checker: every accepted word against the model, and held outputs during stalls.
   initial begin
      logic       stall_prev;
      logic [40:0] held;
      exp_t       e;
      stall_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev)
               check("stall_hold", {22'b0, out_valid, out_data, out_row, out_col, out_last},
                     {22'b0, 1'b1, held});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL extra_word: got %0h expected no word", out_data);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("word%0d", n_xfer),
                        {23'b0, out_data, out_row, out_col, out_last},
                        {23'b0, e.data, e.row, e.col, e.last});
               end
               n_xfer++;
            end
            stall_prev = out_valid && !out_ready;
            held = {out_data, out_row, out_col, out_last};
            if (done) done_cnt++;
         end
      end
   end

   task automatic do_start(input logic cm);
      @(posedge clock);
      #1 start = 1'b1;
      col_major = cm;
      @(posedge clock);
      #1 start = 1'b0;
      col_major = 1'b0;
   endtask

   // Counts negedges until done is seen; n and the first out_valid index are returned.
   task automatic wait_done(output int n, output int first_v);
      first_v = 0;
      for (n = 1; n <= 3000; n++) begin
         @(negedge clock);
         if (first_v == 0 && out_valid) first_v = n;
         if (done) break;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done expected done within 3000 cycles");
      end
   endtask

   task automatic wait_xfers(input int count);
      int base;
      base = n_xfer;
      for (int i = 0; i < 3000 && (n_xfer - base) < count; i++) @(posedge clock);
      if ((n_xfer - base) < count) begin
         n_cmp++;
         n_bad++;
         $display("FAIL xfer_timeout: got %0d expected %0d", n_xfer - base, count);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ctrl"}, {53'b0, busy, done, out_valid, out_last, c_wren, c_address}, 64'd0);
      check({tag, "_data"}, {24'b0, out_data, out_row, out_col}, 64'd0);
      check({tag, "_cdata"}, {32'b0, c_data}, 64'd0);
   endtask

   initial begin
      int n, fv, d0;
      reset = 1'b1;
      start = 1'b0;
      col_major = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            mem[i*N+j] = DW'(i * 256 + j);

      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_state("reset");
      @(posedge clock);
      #1 reset = 1'b0;

      // Model pins
      load_exp(1'b1);
      check("model_cm_w1", {27'b0, exp_q[1].data, exp_q[1].row, exp_q[1].col},
            {27'b0, 32'h0000_0100, 4'd1, 4'd0});
      check("model_cm_w16", {32'b0, exp_q[16].data}, 64'h0000_0001);
      load_exp(1'b0);
      check("model_rm_w0", {31'b0, exp_q[0].data, exp_q[0].last}, 64'd0);
      check("model_rm_last", {31'b0, exp_q[255].data, exp_q[255].last}, {31'b0, 32'h0F0F, 1'b1});

      // Row-major, full rate
      do_start(1'b0);
      wait_done(n, fv);
      check("rm_first_valid", fv, 3);
      check("rm_done_cycle", n, 259);
      check("rm_busy_at_done", {63'b0, busy}, 0);
      check("rm_words_left", exp_q.size(), 0);
      @(negedge clock);
      check("rm_done_pulse", {63'b0, done}, 0);
      check("rm_done_count", done_cnt, 1);

      // Column-major, full rate
      load_exp(1'b1);
      do_start(1'b1);
      wait_done(n, fv);
      check("cm_done_cycle", n, 259);
      check("cm_words_left", exp_q.size(), 0);

      // Random backpressure
      load_exp(1'b0);
      do_start(1'b0);
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge clock);
         #1 out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      check("rand_done_seen", {63'b0, done}, 1);
      check("rand_words_left", exp_q.size(), 0);

      // Held stall for 10 cycles after start, then full-rate release
      load_exp(1'b0);
      @(posedge clock);
      #1 out_ready = 1'b0;
      do_start(1'b0);
      repeat (10) @(posedge clock);
      #1;
      check("stall_valid", {63'b0, out_valid}, 1);
      check("stall_head", {32'b0, out_data}, 0);
      out_ready = 1'b1;
      wait_done(n, fv);
      check("stall_release_cycles", n, 257);
      check("stall_words_left", exp_q.size(), 0);

      // start pulsed mid-pass is ignored
      load_exp(1'b0);
      d0 = done_cnt;
      do_start(1'b0);
      wait_xfers(100);
      #1 start = 1'b1;
      col_major = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      col_major = 1'b0;
      wait_done(n, fv);
      repeat (5) @(negedge clock);
      check("restart_done_count", done_cnt - d0, 1);
      check("restart_words_left", exp_q.size(), 0);
      check("restart_idle", {63'b0, busy}, 0);

      // Reset mid-pass, then a clean pass
      load_exp(1'b0);
      do_start(1'b0);
      wait_xfers(50);
      #1 reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_reset_state("midreset");
      @(posedge clock);
      #1 reset = 1'b0;
      load_exp(1'b0);
      do_start(1'b0);
      wait_done(n, fv);
      check("post_reset_first_valid", fv, 3);
      check("post_reset_done_cycle", n, 259);
      check("post_reset_words_left", exp_q.size(), 0);

      repeat (3) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/c_readout.md
# c_readout

Drains the 32-bit result matrix C from bram_c port B after the compute unit has finished writing it. Issues one read per cycle into the BRAM and streams each word out on a valid/ready interface tagged with row, column and last. Supports row-major or column-major (transposed) order. Sits between bram_c and the host/HPS-facing result path.

## Interface

Parameters:
- DIM, 16: matrix dimension N; DIM*DIM words are read per pass; DIM*DIM ≤ 2^ADDR_W.
- ADDR_W, 8: BRAM address width.
- DATA_W, 32: result word width.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; ignored while busy.
- col_major  in  1  sampled with start; 1 = column-major order.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted.
- c_address  out  ADDR_W  to bram_c address_b.
- c_wren  out  1  to bram_c wren_b; constant 0.
- c_data  out  DATA_W  to bram_c data_b; constant 0.
- c_q  in  DATA_W  from bram_c q_b; valid one cycle after c_address is registered.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  C[row][col].
- out_row  out  ADDR_W/2  row index of out_data.
- out_col  out  ADDR_W/2  column index of out_data.
- out_last  out  1  high with the final word of the pass.

## Operation

- States: IDLE, READ, DRAIN.
- IDLE: start=1 → latch col_major, clear row/col issue counters, busy=1, go READ.
- READ: issue a read when (inflight + FIFO occupancy) < 2; address = row*DIM+col (row-major) or same formula with counters swapped so col advances slowest (column-major). Issue counter inner index wraps DIM-1 → 0 and increments outer index. After issuing word DIM*DIM-1 → DRAIN.
- In-flight word captured from c_q into 2-entry FIFO one cycle after issue, with its row/col/last tag carried alongside.
- DRAIN: no further issues; when FIFO empty and no inflight → done=1 for one cycle, busy=0, IDLE.
- Handshake: transfer when out_valid && out_ready. out_valid never deasserts and out_data/row/col/last never change while out_valid && !out_ready.
- start while busy: ignored, col_major not re-sampled.
- Reset (including mid-pass): state IDLE, FIFO and inflight flag flushed, counters 0.
- Reset values: busy 0, done 0, out_valid 0, out_data 0, out_row 0, out_col 0, out_last 0, c_address 0, c_wren 0, c_data 0.
- c_address held at last value when not issuing (read side-effect free).

## Timing

- start sampled at edge E0; first address driven after E0, registered by BRAM at E0+1, captured into FIFO at E0+2; out_valid first high after E0+2.
- With out_ready held high: one word per cycle, DIM*DIM consecutive transfers, last transfer at edge E0+2+DIM*DIM; done high for the cycle after that edge; busy falls the same edge done rises.
- Backpressure: FIFO depth 2 covers the 1-cycle read latency; full throughput resumes the cycle after out_ready returns high, no bubble.
- Minimum start-to-start spacing: one cycle after done.

## Structure

- Shared package mm_pkg: DIM, ADDR_W, DATA_W, derived IDX_W=ADDR_W/2, state enum for IDLE/READ/DRAIN.
- Sub-module c_skid_fifo: 2-entry FIFO, width DATA_W+2*IDX_W+1, push/pop/full/empty/count; synchronous reset flushes.

## Test plan

- Preload bram_c with C[i][j]=i*256+j, col_major=0, out_ready=1 → 256 words in order 0,1,…,0x0F0F, first valid 2 cycles after start, out_last only on word 255, done one cycle after.
- Same data, col_major=1 → sequence C[0][0],C[1][0],…,C[15][0],C[0][1],…; out_row/out_col match.
- out_ready random 50% → identical sequence, no drop/duplicate, outputs stable during stall.
- Hold out_ready=0 for 10 cycles after start → exactly 2 words buffered, at most 2 reads issued, then full-rate drain when released.
- Pulse start again mid-pass at word 100 → ignored, order unchanged, single done.
- Assert reset at word 50 → all outputs at reset values next cycle; new start reads from address 0 correctly.
